// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables / flushes / perf counters out.
// Latency: none, wires only. Backpressure: carries the cache handshake completions the controller freezes on.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 32
);
    logic              icache_resp;
    logic              dcache_req;
    logic              dcache_resp;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_is_branch;
    logic              ex_mispredict;

    logic              load_pc;
    logic              pc_redirect;
    logic              load_if_id;
    logic              load_id_ex;
    logic              load_ex_mem;
    logic              load_mem_wb;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              pht_update_en;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] mispredicts;
    logic [CNT_WIDTH-1:0] bubbles;

    modport master (
        output icache_resp, dcache_req, dcache_resp, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_branch, ex_mispredict,
        input  load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, pht_update_en, stall_cycles, mispredicts, bubbles
    );

    modport slave (
        input  icache_resp, dcache_req, dcache_resp, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_branch, ex_mispredict,
        output load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, pht_update_en, stall_cycles, mispredicts, bubbles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: stage load enables, bubble insertion, PC redirect, PHT training gate.
// Latency: combinational enables from current state/inputs. Backpressure: cache misses freeze stages.
// Optional perf counters under PIPE_PERF_CNT_EN (otherwise counter outputs tied to 0).
module pipeline_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    logic load_pc;
    logic pc_redirect;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;

    assign mem_stall = hz.dcache_req & ~hz.dcache_resp;
    assign rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
    assign load_use  = hz.ex_is_load & (hz.ex_rd != REG_AW'(0)) & (rs1_hit | rs2_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_pc     = 1'b0;
        pc_redirect = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        if (rst) begin
            state_nxt   = ST_INIT;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            unique case (state)
                ST_INIT: begin
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_nxt   = ST_RUN;
                end
                ST_RUN: begin
                    if (mem_stall) begin
                        state_nxt = ST_RUN;
                    end else if (hz.ex_mispredict && hz.icache_resp) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (hz.ex_mispredict) begin
                        // Wrong-path fetch still outstanding; wait for it before redirecting.
                        state_nxt = ST_DRAIN;
                    end else if (load_use) begin
                        load_id_ex  = 1'b1;
                        flush_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else if (!hz.icache_resp) begin
                        load_if_id  = 1'b1;
                        flush_if_id = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // EX is frozen here, so the mispredict and its target are still valid.
                    if (hz.icache_resp && !mem_stall) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        state_nxt   = ST_RUN;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    assign hz.load_pc       = load_pc;
    assign hz.pc_redirect   = pc_redirect;
    assign hz.load_if_id    = load_if_id;
    assign hz.load_id_ex    = load_id_ex;
    assign hz.load_ex_mem   = load_ex_mem;
    assign hz.load_mem_wb   = load_mem_wb;
    assign hz.flush_if_id   = flush_if_id;
    assign hz.flush_id_ex   = flush_id_ex;
    // The branch stays in EX while frozen; gating on load_ex_mem trains it only as it leaves.
    assign hz.pht_update_en = hz.ex_is_branch & load_ex_mem & ~rst;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;
    logic [CNT_WIDTH-1:0] bubble_cnt;
    logic                 stall_hit;
    logic                 bubble_hit;

    assign stall_hit  = ~load_pc & (state != ST_INIT);
    assign bubble_hit = (flush_if_id & load_if_id) | (flush_id_ex & load_id_ex);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            mispred_cnt <= '0;
            bubble_cnt  <= '0;
        end else begin
            if (stall_hit && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (pc_redirect && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
            end
            if (bubble_hit && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.mispredicts  = mispred_cnt;
    assign hz.bubbles      = bubble_cnt;
`else
    assign hz.stall_cycles = CNT_WIDTH'(0);
    assign hz.mispredicts  = CNT_WIDTH'(0);
    assign hz.bubbles      = CNT_WIDTH'(0);
`endif
endmodule
